alu_cc_pipe: RTL and testbench
==============================

// Module: alu_cc_pipe
// PURPOSE
//   Parametrised, registered Y86-64 ALU stage: ADD/SUB/AND/XOR on WIDTH-bit operands with valid/ready
//   handshake and a condition-code register (ZF, SF, OF). Successor to the combinational 64-bit
//   AND/ADD/SUB/XOR units; sits between decode/register-read and memory in the execute stage.
// PARAMETERS
//   WIDTH     64  operand/result width in bits (>=2)
//   CC_RESET  3'b100  reset value of {ZF,SF,OF}
// PORTS
//   clk        in   1      single clock, all state on posedge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      stage can accept bundle this cycle
//   in_op      in   2      0=ADD 1=SUB 2=AND 3=XOR (Y86 ifun encoding)
//   in_a       in   WIDTH  valA
//   in_b       in   WIDTH  valB
//   in_set_cc  in   1      update CC register when this op is accepted (OPq only)
//   out_valid  out  1      result held valid
//   out_ready  in   1      downstream accepts result
//   out_result out  WIDTH  valE
//   out_cc     out  3      {ZF,SF,OF} computed for the held result
//   cc         out  3      architectural CC register {ZF,SF,OF}
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_valid=0, out_result=0, out_cc=0, cc=CC_RESET; in-flight op discarded.
//   - in_ready = !out_valid | out_ready (combinational; single output register, no bubble on stream).
//   - Accept = in_valid & in_ready. On accept: out_result/out_cc load next posedge, out_valid=1.
//     Latency 1 cycle. Throughput 1/cycle while out_ready=1.
//   - out_valid & !out_ready: out_result, out_cc held stable; in_ready=0; no accept.
//   - out_valid & out_ready & no accept: out_valid->0 next cycle; out_result keeps last value.
//   - Simultaneous drain and accept: new result replaces old in same edge, out_valid stays 1.
//   - Arithmetic, modulo 2^WIDTH, carry discarded:
//     ADD r=b+a; SUB r=b-a; AND r=a&b; XOR r=a^b.
//   - Flags: ZF=(r==0); SF=r[WIDTH-1];
//     OF ADD=(a[msb]==b[msb])&(r[msb]!=a[msb]); OF SUB=(a[msb]!=b[msb])&(r[msb]!=b[msb]);
//     OF AND/XOR=0.
//   - cc loads flags on the accept edge when in_set_cc=1 (not on drain); else cc holds.
//   - Reset mid-stall: output dropped, cc reset; first post-reset cycle in_ready=1.
//   - No X propagation: in_op/in_a/in_b ignored when in_valid=0.
// STRUCTURE
//   - Shared package/header: op codes ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3;
//     CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
//   - Sub-module alu_core #(WIDTH): purely combinational (op,a,b)->(r,zf,sf,of); this block
//     adds handshake register and cc register around it.
// TESTING (WIDTH=64)
//   1. rst 2 cycles -> out_valid=0, cc=3'b100, in_ready=1.
//   2. ADD a=0x7FFF_FFFF_FFFF_FFFF b=1, set_cc=1 -> next cycle result=0x8000_0000_0000_0000,
//      out_cc=3'b011, cc=3'b011.
//   3. SUB a=5 b=5 then AND a=0x26 b=0x31 (set_cc=0), out_ready=1 back-to-back ->
//      results 0 (cc=3'b100) then 0x20 on consecutive cycles; cc stays 3'b100.
//   4. XOR a=-0x2D b=0x15, out_ready=0 for 3 cycles -> result 0xFFFF_FFFF_FFFF_FFC6 held,
//      in_ready=0, second bundle not accepted until out_ready=1.
//   5. SUB a=1 b=0x8000_0000_0000_0000 -> result 0x7FFF_FFFF_FFFF_FFFF, out_cc=3'b001.
//   6. Assert rst while out_valid=1 & stalled -> out_valid=0, cc=3'b100 next cycle; held op lost.

Source files
------------

// File: rtl/alu_cc_pkg.sv
// Shared op codes and condition-code bit positions for the execute-stage ALU.
package alu_cc_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Pack the individual flags into the {ZF,SF,OF} layout.
  function automatic logic [2:0] pack_cc(input logic zf, input logic sf, input logic of);
    logic [2:0] f;
    f = '0;
    f[CC_ZF] = zf;
    f[CC_SF] = sf;
    f[CC_OF] = of;
    return f;
  endfunction
endpackage

// File: rtl/alu_cc_pipe_core.sv
// Combinational Y86-64 ALU: result plus ZF/SF/OF for one operand pair.
module alu_core
  import alu_cc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  logic am, bm, rm;

  always_comb begin
    r = '0;
    case (op)
      ALU_ADD: r = b + a;
      ALU_SUB: r = b - a;
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
  end

  assign am = a[WIDTH-1];
  assign bm = b[WIDTH-1];
  assign rm = r[WIDTH-1];
  assign zf = (r == '0);
  assign sf = rm;

  // Signed overflow only exists for ADD/SUB; logic ops never overflow.
  always_comb begin
    of = 1'b0;
    case (op)
      ALU_ADD: of = (am == bm) && (rm != am);
      ALU_SUB: of = (am != bm) && (rm != bm);
      default: of = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_cc_pipe.sv
// Registered ALU stage: single output register with valid/ready and an architectural CC register.
module alu_cc_pipe
  import alu_cc_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_cc,
  output logic [2:0]       cc
);
  logic [WIDTH-1:0] r;
  logic             zf, sf, of;
  logic [2:0]       flags;
  logic             acc;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op (in_op),
    .a  (in_a),
    .b  (in_b),
    .r  (r),
    .zf (zf),
    .sf (sf),
    .of (of)
  );

  assign flags    = pack_cc(zf, sf, of);
  // Register frees up in the same cycle it drains, so a stream runs without bubbles.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cc     <= '0;
      cc         <= CC_RESET;
    end else begin
      if (acc) begin
        out_valid  <= 1'b1;
        out_result <= r;
        out_cc     <= flags;
        if (in_set_cc) cc <= flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cc_pipe.sv
// Directed-vector bench for alu_cc_pipe at WIDTH=64.
module tb_alu_cc_pipe;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_set_cc;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_cc, cc;

  int checks = 0;
  int failures = 0;

  alu_cc_pipe #(.WIDTH(W), .CC_RESET(3'b100)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_set_cc  (in_set_cc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cc     (out_cc),
    .cc         (cc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sc);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_set_cc = sc;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", cc); end
    checks++; if (out_result !== '0 || out_cc !== 3'b000) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/000", out_result, out_cc); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_of();
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_result got=%b/%h exp=1/8000000000000000", out_valid, out_result); end
    checks++; if (out_cc !== 3'b011) begin failures++; $display("FAIL add_outcc got=%b exp=011", out_cc); end
    checks++; if (cc !== 3'b011) begin failures++; $display("FAIL add_cc got=%b exp=011", cc); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_result !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_drain got=%b/%h exp=0/8000000000000000", out_valid, out_result); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 2'd1, 64'd5, 64'd5, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== '0 || out_cc !== 3'b100) begin failures++; $display("FAIL b2b_sub got=%b/%h/%b exp=1/0/100", out_valid, out_result, out_cc); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL b2b_sub_cc got=%b exp=100", cc); end
    drive(1'b1, 2'd2, 64'h26, 64'h31, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'h20 || out_cc !== 3'b000) begin failures++; $display("FAIL b2b_and got=%b/%h/%b exp=1/20/000", out_valid, out_result, out_cc); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL b2b_and_cc got=%b exp=100", cc); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 2'd3, -64'sd45, 64'h15, 1'b0);
    tick();
    drive(1'b1, 2'd0, 64'd1, 64'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFC6 || out_cc !== 3'b010) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%b exp=1/ffffffffffffffc6/010", i, out_valid, out_result, out_cc); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
    end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL stall_cc got=%b exp=100", cc); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd3 || cc !== 3'b000) begin failures++; $display("FAIL stall_second got=%b/%h/%b exp=1/3/000", out_valid, out_result, cc); end
    tick();
  endtask

  task automatic test_sub_of();
    out_ready = 1'b1;
    drive(1'b1, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_result !== 64'h7FFF_FFFF_FFFF_FFFF || out_cc !== 3'b001) begin failures++; $display("FAIL sub_of got=%h/%b exp=7fffffffffffffff/001", out_result, out_cc); end
    checks++; if (cc !== 3'b001) begin failures++; $display("FAIL sub_of_cc got=%b exp=001", cc); end
    tick();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 64'd2, 64'd3, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd5 || cc !== 3'b000) begin failures++; $display("FAIL rs_pre got=%b/%h/%b exp=1/5/000", out_valid, out_result, cc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || cc !== 3'b100 || out_result !== '0) begin failures++; $display("FAIL rs_post got=%b/%b/%h exp=0/100/0", out_valid, cc, out_result); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rs_ready got=%b exp=1", in_ready); end
    drive(1'b1, 2'd0, 64'd4, 64'd5, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd9 || cc !== 3'b100) begin failures++; $display("FAIL rs_accept got=%b/%h/%b exp=1/9/100", out_valid, out_result, cc); end
  endtask

  initial begin
    test_reset();
    test_add_of();
    test_back_to_back();
    test_stall();
    test_sub_of();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
